// File: rtl/pipeline_trace_unit_pkg.sv
// Shared definitions for the pipeline trace unit: FSM encoding, record layout
// and the record-width helper used by the top and the bench.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_INSTR_W = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_REG_W   = 4;
    localparam int DEF_TS_W    = 16;

    // Record layout, LSB first: data, reg, instr, pc, ts, wv, fv, ovf.
    localparam int OFF_DATA  = 0;
    localparam int OFF_REG   = OFF_DATA + DEF_DATA_W;
    localparam int OFF_INSTR = OFF_REG + DEF_REG_W;
    localparam int OFF_PC    = OFF_INSTR + DEF_INSTR_W;
    localparam int OFF_TS    = OFF_PC + DEF_ADDR_W;
    localparam int OFF_WV    = OFF_TS + DEF_TS_W;
    localparam int OFF_FV    = OFF_WV + 1;
    localparam int OFF_OVF   = OFF_FV + 1;

    function automatic int rec_width(input int ts_w, input int addr_w, input int instr_w,
                                     input int reg_w, input int data_w);
        return ts_w + addr_w + instr_w + reg_w + data_w + 3;
    endfunction

    localparam int REC_W = rec_width(DEF_TS_W, DEF_ADDR_W, DEF_INSTR_W, DEF_REG_W, DEF_DATA_W);

endpackage

// File: rtl/pipeline_trace_unit_if.sv
// Trace record stream. A record transfers on any rising edge where
// trace_valid && trace_ready; trace_data is stable while valid is held without ready.
interface pipeline_trace_unit_if #(
    parameter int REC_W = 71
);
    logic             trace_valid;
    logic             trace_ready;
    logic [REC_W-1:0] trace_data;

    modport master (output trace_valid, output trace_data, input trace_ready);
    modport slave  (input trace_valid, input trace_data, output trace_ready);
endinterface

// File: rtl/pipeline_trace_unit_fifo.sv
// Synchronous show-ahead FIFO; the head entry is presented combinationally and
// reads as zero while empty.
module trace_fifo #(
    parameter int WIDTH = 71,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // The extra wrap bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign pop_data = empty ? '0 : mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_trace_unit.sv
// Samples IF fetch and WB writeback each cycle, packs them into timestamped
// records during a PC-triggered capture window and streams them out of a FIFO.
module pipeline_trace_unit
    import trace_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int INSTR_W     = 16,
    parameter int DATA_W      = 16,
    parameter int REG_W       = 4,
    parameter int TS_W        = 16,
    parameter int DEPTH       = 16,
    parameter int CAPTURE_LEN = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               arm,
    input  logic [ADDR_W-1:0]  trigger_pc,
    input  logic               if_valid,
    input  logic [ADDR_W-1:0]  if_pc,
    input  logic [INSTR_W-1:0] if_instruction,
    input  logic               wb_reg_write,
    input  logic [REG_W-1:0]   wb_write_reg,
    input  logic [DATA_W-1:0]  wb_write_data,
    input  logic               cpu_halt,
    pipeline_trace_unit_if.master trace,
    output logic [1:0]         state,
    output logic [7:0]         dropped_count
);
    localparam int RW    = rec_width(TS_W, ADDR_W, INSTR_W, REG_W, DATA_W);
    localparam int CNT_W = 16;

    trace_state_e     state_q;
    trace_state_e     state_d;
    logic [TS_W-1:0]  ts;
    logic [CNT_W-1:0] rec_count;
    logic             rec_clear;
    logic             ovf_pending;

    logic             trig_hit;
    logic             in_window;
    logic             push_req;
    logic             last_push;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [RW-1:0]    record;
    logic [RW-1:0]    head;

    assign trig_hit  = if_valid && (if_pc == trigger_pc);
    // The trigger cycle itself belongs to the capture window.
    assign in_window = (state_q == ST_CAPTURE) || ((state_q == ST_ARMED) && trig_hit);
    assign push_req  = in_window && (if_valid || wb_reg_write);
    assign last_push = push_req && (CAPTURE_LEN != 0) &&
                       (rec_count == CNT_W'(CAPTURE_LEN - 1));

    assign pop     = trace.trace_valid && trace.trace_ready;
    assign push_ok = push_req && (!fifo_full || pop);
    assign drop    = push_req && fifo_full && !pop;

    assign record = {ovf_pending, if_valid, wb_reg_write, ts,
                     if_valid     ? if_pc          : {ADDR_W{1'b0}},
                     if_valid     ? if_instruction : {INSTR_W{1'b0}},
                     wb_reg_write ? wb_write_reg   : {REG_W{1'b0}},
                     wb_reg_write ? wb_write_data  : {DATA_W{1'b0}}};

    always_comb begin
        state_d   = state_q;
        rec_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d   = ST_ARMED;
                    rec_clear = 1'b1;
                end
            end
            ST_ARMED: begin
                if (trig_hit) begin
                    state_d = (cpu_halt || last_push) ? ST_DONE : ST_CAPTURE;
                end else if (cpu_halt) begin
                    state_d = ST_DONE;
                end
            end
            ST_CAPTURE: begin
                if (last_push || cpu_halt) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (arm) begin
                    state_d   = ST_ARMED;
                    rec_clear = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ts            <= '0;
            rec_count     <= '0;
            ovf_pending   <= 1'b0;
            dropped_count <= '0;
        end else begin
            state_q <= state_d;
            ts      <= ts + 1'b1;
            if (rec_clear)     rec_count <= '0;
            else if (push_req) rec_count <= rec_count + 1'b1;
            if (drop) begin
                ovf_pending <= 1'b1;
                if (dropped_count != 8'hFF) dropped_count <= dropped_count + 1'b1;
            end else if (push_ok) begin
                ovf_pending <= 1'b0;
            end
        end
    end

    trace_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_ok),
        .push_data (record),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign trace.trace_valid = !fifo_empty;
    assign trace.trace_data  = head;
    assign state             = state_q;

endmodule

// File: tb/tb_pipeline_trace_unit.sv
// Directed bench for pipeline_trace_unit: dut_a uses CAPTURE_LEN=64, dut_b uses
// CAPTURE_LEN=4; both see the same stimulus.
module tb_pipeline_trace_unit;
    import trace_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic [15:0] trigger_pc = '0;
    logic        if_valid = 1'b0;
    logic [15:0] if_pc = '0;
    logic [15:0] if_instruction = '0;
    logic        wb_reg_write = 1'b0;
    logic [3:0]  wb_write_reg = '0;
    logic [15:0] wb_write_data = '0;
    logic        cpu_halt = 1'b0;
    logic        ready = 1'b0;

    logic [1:0]  state_a, state_b;
    logic [7:0]  dropped_a, dropped_b;

    logic [15:0] tb_ts = '0;
    logic [70:0] exp_q[$];
    logic [70:0] exp_rec;
    int          errors = 0;
    int          checks = 0;

    pipeline_trace_unit_if #(.REC_W(71)) trace_a ();
    pipeline_trace_unit_if #(.REC_W(71)) trace_b ();
    assign trace_a.trace_ready = ready;
    assign trace_b.trace_ready = ready;

    pipeline_trace_unit #(.CAPTURE_LEN(64)) dut_a (
        .clock(clock), .reset(reset), .arm(arm), .trigger_pc(trigger_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .cpu_halt(cpu_halt), .trace(trace_a),
        .state(state_a), .dropped_count(dropped_a)
    );

    pipeline_trace_unit #(.CAPTURE_LEN(4)) dut_b (
        .clock(clock), .reset(reset), .arm(arm), .trigger_pc(trigger_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .cpu_halt(cpu_halt), .trace(trace_b),
        .state(state_b), .dropped_count(dropped_b)
    );

    // Clock / reset
    always #5 clock = ~clock;

    function automatic logic [70:0] make_rec(input logic ovf, input logic fv, input logic wv,
                                             input logic [15:0] ts, input logic [15:0] pc,
                                             input logic [15:0] instr, input logic [3:0] r,
                                             input logic [15:0] d);
        return {ovf, fv, wv, ts, fv ? pc : 16'h0, fv ? instr : 16'h0, wv ? r : 4'h0, wv ? d : 16'h0};
    endfunction

    // Driver tasks
    task automatic cycle();
        @(posedge clock);
        if (reset) tb_ts = '0;
        else tb_ts = tb_ts + 16'd1;
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) cycle();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
    endtask

    task automatic push(input logic fv, input logic [15:0] pc, input logic [15:0] instr,
                        input logic wv, input logic [3:0] r, input logic [15:0] d,
                        input logic expect_rec, input logic ovf);
        if_valid = fv; if_pc = pc; if_instruction = instr;
        wb_reg_write = wv; wb_write_reg = r; wb_write_data = d;
        if (expect_rec) exp_q.push_back(make_rec(ovf, fv, wv, tb_ts, pc, instr, r, d));
        cycle();
        if_valid = 1'b0; wb_reg_write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++; if (state_a !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_a); end
        checks++; if (trace_a.trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", trace_a.trace_valid); end
        checks++; if (trace_a.trace_data !== 71'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", trace_a.trace_data); end
        trigger_pc = 16'h0010;
        pulse_arm();
        push(1, 16'h0010, 16'hA001, 0, 0, 0, 0, 0);
        push(1, 16'h0012, 16'hA002, 0, 0, 0, 0, 0);
        push(1, 16'h0014, 16'hA003, 0, 0, 0, 0, 0);
        checks++; if (state_a !== 2'd2 || trace_a.trace_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_capture state=%0d valid=%b exp=2/1", state_a, trace_a.trace_valid); end
        do_reset(2);
        checks++; if (state_a !== 2'd0) begin errors++; $display("FAIL midcap_reset_state got=%0d exp=0", state_a); end
        checks++; if (trace_a.trace_valid !== 1'b0) begin errors++; $display("FAIL midcap_reset_valid got=%b exp=0", trace_a.trace_valid); end
        checks++; if (dropped_a !== 8'd0) begin errors++; $display("FAIL midcap_reset_dropped got=%0d exp=0", dropped_a); end
    endtask

    task automatic test_trigger();
        trigger_pc = 16'h0004;
        pulse_arm();
        checks++; if (state_a !== 2'd1) begin errors++; $display("FAIL arm_state got=%0d exp=1", state_a); end
        push(1, 16'h0000, 16'hB000, 0, 0, 0, 0, 0);
        push(1, 16'h0002, 16'hB002, 0, 0, 0, 0, 0);
        checks++; if (trace_a.trace_valid !== 1'b0) begin errors++; $display("FAIL pre_trigger_valid got=%b exp=0", trace_a.trace_valid); end
        push(1, 16'h0004, 16'hB004, 0, 0, 0, 1, 0);
        push(1, 16'h0006, 16'hB006, 0, 0, 0, 1, 0);
        checks++; if (state_a !== 2'd2) begin errors++; $display("FAIL trigger_state got=%0d exp=2", state_a); end
        for (int i = 0; i < 2; i++) begin
            exp_rec = exp_q.pop_front();
            checks++; if (trace_a.trace_data !== exp_rec || trace_a.trace_valid !== 1'b1) begin errors++; $display("FAIL trigger_rec%0d got=%h exp=%h", i, trace_a.trace_data, exp_rec); end
            ready = 1'b1; cycle(); ready = 1'b0;
        end
        checks++; if (trace_a.trace_valid !== 1'b0) begin errors++; $display("FAIL trigger_count extra record valid=%b exp=0", trace_a.trace_valid); end
    endtask

    task automatic test_simultaneous();
        push(1, 16'h0006, 16'h1234, 1, 4'd3, 16'hBEEF, 1, 0);
        push(0, 16'h0000, 16'h0000, 1, 4'd5, 16'h5555, 1, 0);
        checks++; if (trace_a.trace_data[OFF_FV] !== 1'b1 || trace_a.trace_data[OFF_WV] !== 1'b1) begin errors++; $display("FAIL simul_flags got fv=%b wv=%b exp=1/1", trace_a.trace_data[OFF_FV], trace_a.trace_data[OFF_WV]); end
        for (int i = 0; i < 2; i++) begin
            exp_rec = exp_q.pop_front();
            checks++; if (trace_a.trace_data !== exp_rec || trace_a.trace_valid !== 1'b1) begin errors++; $display("FAIL simul_rec%0d got=%h exp=%h", i, trace_a.trace_data, exp_rec); end
            ready = 1'b1; cycle(); ready = 1'b0;
        end
        checks++; if (trace_a.trace_valid !== 1'b0) begin errors++; $display("FAIL simul_count valid=%b exp=0", trace_a.trace_valid); end
    endtask

    task automatic test_overflow();
        do_reset(1);
        trigger_pc = 16'h0100;
        pulse_arm();
        for (int i = 0; i < 18; i++) begin
            push(1, 16'h0100 + 16'(2 * i), 16'(i), 0, 0, 0, (i < 16), 0);
        end
        checks++; if (dropped_a !== 8'd2) begin errors++; $display("FAIL ovf_dropped got=%0d exp=2", dropped_a); end
        for (int i = 0; i < 16; i++) begin
            exp_rec = exp_q.pop_front();
            checks++; if (trace_a.trace_data !== exp_rec || trace_a.trace_valid !== 1'b1) begin errors++; $display("FAIL ovf_stored%0d got=%h exp=%h", i, trace_a.trace_data, exp_rec); end
            ready = 1'b1; cycle(); ready = 1'b0;
        end
        checks++; if (trace_a.trace_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained valid=%b exp=0", trace_a.trace_valid); end
        push(0, 0, 0, 1, 4'd1, 16'h0001, 1, 1);
        push(0, 0, 0, 1, 4'd2, 16'h0002, 1, 0);
        for (int i = 0; i < 2; i++) begin
            exp_rec = exp_q.pop_front();
            checks++; if (trace_a.trace_data !== exp_rec) begin errors++; $display("FAIL ovf_flag%0d got=%h exp=%h", i, trace_a.trace_data, exp_rec); end
            ready = 1'b1; cycle(); ready = 1'b0;
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 16; i++) begin
            push(0, 0, 0, 1, 4'(i), 16'hC000 + 16'(i), 1, 0);
        end
        // Full FIFO: push and pop in the same cycle.
        if_valid = 1'b1; if_pc = 16'h0F00; if_instruction = 16'hDEAD; ready = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back(make_rec(0, 1, 0, tb_ts, 16'h0F00, 16'hDEAD, 0, 0));
        cycle();
        if_valid = 1'b0; ready = 1'b0;
        checks++; if (dropped_a !== 8'd2) begin errors++; $display("FAIL fullpop_dropped got=%0d exp=2", dropped_a); end
        for (int i = 0; i < 16; i++) begin
            exp_rec = exp_q.pop_front();
            checks++; if (trace_a.trace_data !== exp_rec || trace_a.trace_valid !== 1'b1) begin errors++; $display("FAIL fullpop_rec%0d got=%h exp=%h", i, trace_a.trace_data, exp_rec); end
            ready = 1'b1; cycle(); ready = 1'b0;
        end
        checks++; if (trace_a.trace_valid !== 1'b0) begin errors++; $display("FAIL fullpop_drained valid=%b exp=0", trace_a.trace_valid); end
    endtask

    task automatic test_end();
        int pops;
        do_reset(1);
        trigger_pc = 16'h0020;
        pulse_arm();
        checks++; if (state_b !== 2'd1) begin errors++; $display("FAIL end_arm got=%0d exp=1", state_b); end
        push(1, 16'h0020, 16'h0, 0, 0, 0, 0, 0);
        push(1, 16'h0022, 16'h0, 0, 0, 0, 0, 0);
        push(1, 16'h0024, 16'h0, 0, 0, 0, 0, 0);
        checks++; if (state_b !== 2'd2) begin errors++; $display("FAIL end_capture got=%0d exp=2", state_b); end
        pulse_arm();
        checks++; if (state_b !== 2'd2) begin errors++; $display("FAIL end_arm_ignored got=%0d exp=2", state_b); end
        push(1, 16'h0026, 16'h0, 0, 0, 0, 0, 0);
        checks++; if (state_b !== 2'd3) begin errors++; $display("FAIL end_len_done got=%0d exp=3", state_b); end
        pulse_arm();
        checks++; if (state_b !== 2'd1 || trace_b.trace_valid !== 1'b1) begin errors++; $display("FAIL end_rearm state=%0d valid=%b exp=1/1", state_b, trace_b.trace_valid); end
        push(1, 16'h0020, 16'h0, 0, 0, 0, 0, 0);
        cpu_halt = 1'b1;
        push(1, 16'h0022, 16'h0, 0, 0, 0, 0, 0);
        cpu_halt = 1'b0;
        checks++; if (state_b !== 2'd3) begin errors++; $display("FAIL end_halt_capture got=%0d exp=3", state_b); end
        pulse_arm();
        cpu_halt = 1'b1; cycle(); cpu_halt = 1'b0;
        checks++; if (state_b !== 2'd3) begin errors++; $display("FAIL end_halt_armed got=%0d exp=3", state_b); end
        pops = 0;
        ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (trace_b.trace_valid === 1'b1) pops++;
            cycle();
        end
        ready = 1'b0;
        checks++; if (pops !== 6) begin errors++; $display("FAIL end_record_count got=%0d exp=6", pops); end
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_simultaneous();
        test_overflow();
        test_full_pop();
        test_end();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
